// File: rtl/pwm_motor_sequencer.sv
// Four-channel ESC sequencer: arming hold, frame-aligned slew-limited duty
// updates, command watchdog and sticky failsafe. All channels load together.

// Per-channel datapath: command clamp and one-frame slew step toward target.
module pwm_slew_lane #(
  parameter int W    = 16,
  parameter int MIN  = 1000,
  parameter int MAX  = 2000,
  parameter int STEP = 20
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] cmd,
  output logic [W-1:0] slewed,
  output logic [W-1:0] clamped
);
  localparam logic signed [W:0] STEP_S = (W+1)'(STEP);

  logic signed [W:0] d;

  // Signed distance to target; step by at most STEP, land exactly when close.
  always_comb begin
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S)       slewed = cur + W'(STEP);
    else if (d < -STEP_S) slewed = cur - W'(STEP);
    else                  slewed = tgt;
  end

  // Unsigned clamp of the incoming command into the ESC range.
  always_comb begin
    if (cmd < W'(MIN))      clamped = W'(MIN);
    else if (cmd > W'(MAX)) clamped = W'(MAX);
    else                    clamped = cmd;
  end
endmodule

module pwm_motor_sequencer #(
  parameter int DUTY_WIDTH  = 16,
  parameter int DUTY_MIN    = 1000,
  parameter int DUTY_MAX    = 2000,
  parameter int ARM_FRAMES  = 50,
  parameter int SLEW_STEP   = 20,
  parameter int WDOG_FRAMES = 25
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic                    frame_tick,
  input  logic                    arm_req,
  input  logic                    disarm_req,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4*DUTY_WIDTH-1:0] cmd_duty,
  output logic [4*DUTY_WIDTH-1:0] duty_out,
  output logic                    duty_load,
  output logic                    armed,
  output logic                    failsafe,
  output logic [1:0]              state
);
  localparam int NUM_CH = 4;
  localparam int FW     = $clog2(ARM_FRAMES + 1);
  localparam int WW     = $clog2(WDOG_FRAMES + 1);
  localparam logic [DUTY_WIDTH-1:0] DMIN = DUTY_WIDTH'(DUTY_MIN);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARM_HOLD = 2'd1,
    S_ARMED    = 2'd2,
    S_FAILSAFE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [NUM_CH-1:0][DUTY_WIDTH-1:0] duty_q, duty_d, target_q, target_d;
  logic [NUM_CH-1:0][DUTY_WIDTH-1:0] slewed, clamped;
  logic [FW-1:0] frame_q, frame_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          load_q, load_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pwm_slew_lane #(
      .W(DUTY_WIDTH), .MIN(DUTY_MIN), .MAX(DUTY_MAX), .STEP(SLEW_STEP)
    ) u_lane (
      .cur    (duty_q[i]),
      .tgt    (target_q[i]),
      .cmd    (cmd_duty[i*DUTY_WIDTH +: DUTY_WIDTH]),
      .slewed (slewed[i]),
      .clamped(clamped[i])
    );
  end

  assign accept = cmd_valid & cmd_ready_q;

  // Next-state: disarm overrides everything; otherwise per-state sequencing.
  // Slew reads target_q, so a command landing with a tick applies next frame.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;
    frame_d     = frame_q;
    wdog_d      = wdog_q;
    load_d      = frame_tick;
    cmd_ready_d = 1'b1;
    if (disarm_req) begin
      state_d = S_DISARMED;
      load_d  = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_d[i]   = DMIN;
        target_d[i] = DMIN;
      end
    end else begin
      case (state_q)
        S_DISARMED: begin
          for (int i = 0; i < NUM_CH; i++) duty_d[i] = DMIN;
          if (arm_req) begin
            state_d = S_ARM_HOLD;
            frame_d = '0;
            for (int i = 0; i < NUM_CH; i++) target_d[i] = DMIN;
          end
        end
        S_ARM_HOLD: begin
          for (int i = 0; i < NUM_CH; i++) duty_d[i] = DMIN;
          if (frame_tick) begin
            if (frame_q == FW'(ARM_FRAMES - 1)) begin
              state_d = S_ARMED;
              frame_d = '0;
              wdog_d  = '0;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (frame_tick) duty_d = slewed;
          if (accept) begin
            target_d = clamped;
            wdog_d   = '0;
          end else if (frame_tick) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == WW'(WDOG_FRAMES - 1)) state_d = S_FAILSAFE;
          end
        end
        default: begin
          if (frame_tick)
            for (int i = 0; i < NUM_CH; i++) duty_d[i] = DMIN;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q     <= S_DISARMED;
      frame_q     <= '0;
      wdog_q      <= '0;
      load_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]   <= DMIN;
        target_q[i] <= DMIN;
      end
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      frame_q     <= frame_d;
      wdog_q      <= wdog_d;
      load_q      <= load_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign duty_out  = duty_q;
  assign duty_load = load_q;
  assign cmd_ready = cmd_ready_q;
  assign state     = state_q;
  assign armed     = (state_q == S_ARMED);
  assign failsafe  = (state_q == S_FAILSAFE);
endmodule

// File: tb/tb_pwm_motor_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed frame results, the monitor
// pops one entry per duty_load pulse and compares duties and status.
module tb_pwm_motor_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, arm_req = 1'b0, disarm_req = 1'b0, cmd_valid = 1'b0;
  logic [63:0] cmd_duty = '0;
  logic        cmd_ready, duty_load, armed, failsafe;
  logic [63:0] duty_out;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] duty;
    logic [1:0]  st;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pwm_motor_sequencer dut (
    .s00_axi_aclk  (clk),
    .s00_axi_areset(rst),
    .frame_tick    (frame_tick),
    .arm_req       (arm_req),
    .disarm_req    (disarm_req),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_duty      (cmd_duty),
    .duty_out      (duty_out),
    .duty_load     (duty_load),
    .armed         (armed),
    .failsafe      (failsafe),
    .state         (state)
  );

  function automatic logic [63:0] pk(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(logic [63:0] d, logic [1:0] st);
    exp_t e;
    e.duty = d;
    e.st   = st;
    q.push_back(e);
  endtask

  // Monitor: every load strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (duty_load === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_load: duty %h state %0d with nothing expected", duty_out, state);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (duty_out !== e.duty || state !== e.st ||
            armed !== (e.st == 2'd2) || failsafe !== (e.st == 2'd3)) begin
          n_bad++;
          $display("FAIL frame_load: got duty %h st %0d arm %b fs %b expected duty %h st %0d",
                   duty_out, state, armed, failsafe, e.duty, e.st);
        end
      end
    end
  end

  task automatic tick(logic [63:0] d, logic [1:0] st);
    @(negedge clk);
    frame_tick = 1'b1;
    push(d, st);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick_cmd(logic [63:0] cmdv, logic [63:0] d, logic [1:0] st);
    @(negedge clk);
    frame_tick = 1'b1;
    cmd_valid  = 1'b1;
    cmd_duty   = cmdv;
    push(d, st);
    @(negedge clk);
    frame_tick = 1'b0;
    cmd_valid  = 1'b0;
  endtask

  task automatic send_cmd(logic [63:0] cmdv);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_duty  = cmdv;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic arm_seq();
    @(negedge clk);
    arm_req = 1'b1;
    @(negedge clk);
    arm_req = 1'b0;
    chk("arm_hold_entry", 64'(state), 64'd1);
    for (int i = 1; i <= 50; i++)
      tick(pk(1000, 1000, 1000, 1000), (i == 50) ? 2'd2 : 2'd1);
  endtask

  task automatic disarm(bit with_arm);
    @(negedge clk);
    disarm_req = 1'b1;
    arm_req    = with_arm;
    push(pk(1000, 1000, 1000, 1000), 2'd0);
    @(negedge clk);
    disarm_req = 1'b0;
    arm_req    = 1'b0;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_state"}, 64'(state), 64'd0);
    chk({nm, "_duty"}, duty_out, pk(1000, 1000, 1000, 1000));
    chk({nm, "_flags"}, {61'd0, duty_load, armed, failsafe}, 64'd0);
    chk({nm, "_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  initial begin
    // 1. Reset and arming
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    tick(pk(1000, 1000, 1000, 1000), 2'd0);
    arm_seq();
    chk("armed_flag", {62'd0, armed, failsafe}, 64'd2);

    // 2. Slew limiting with clamp, then ramp down
    send_cmd(pk(1500, 1010, 1000, 2500));
    tick(pk(1020, 1010, 1000, 1020), 2'd2);
    tick(pk(1040, 1010, 1000, 1040), 2'd2);
    tick(pk(1060, 1010, 1000, 1060), 2'd2);
    send_cmd(pk(1000, 1000, 1000, 1000));
    tick(pk(1040, 1000, 1000, 1040), 2'd2);
    tick(pk(1020, 1000, 1000, 1020), 2'd2);
    tick(pk(1000, 1000, 1000, 1000), 2'd2);

    // 3. Watchdog expiry, failsafe drop, ignored command, disarm
    send_cmd(pk(1100, 1100, 1100, 1100));
    for (int k = 1; k <= 25; k++) begin
      int v;
      v = (1000 + 20 * k > 1100) ? 1100 : 1000 + 20 * k;
      tick(pk(v, v, v, v), (k == 25) ? 2'd3 : 2'd2);
    end
    tick(pk(1000, 1000, 1000, 1000), 2'd3);
    send_cmd(pk(1500, 1500, 1500, 1500));
    tick(pk(1000, 1000, 1000, 1000), 2'd3);
    disarm(1'b0);

    // 4. Command on the 25th tick clears watchdog; slew uses the old target
    arm_seq();
    for (int k = 1; k <= 24; k++) tick(pk(1000, 1000, 1000, 1000), 2'd2);
    tick_cmd(pk(1200, 1200, 1200, 1200), pk(1000, 1000, 1000, 1000), 2'd2);
    for (int k = 1; k <= 24; k++) begin
      int v;
      v = (1000 + 20 * k > 1200) ? 1200 : 1000 + 20 * k;
      tick(pk(v, v, v, v), 2'd2);
    end

    // 5. Disarm beats arm while running at 1400
    send_cmd(pk(1400, 1400, 1400, 1400));
    for (int k = 1; k <= 10; k++) begin
      int v;
      v = 1200 + 20 * k;
      tick(pk(v, v, v, v), 2'd2);
    end
    disarm(1'b1);
    @(negedge clk);
    chk("stay_disarmed", {61'd0, state, armed}, 64'd0);

    // 6. Reset during ARM_HOLD with a coincident tick
    arm_seq_partial: begin
      @(negedge clk);
      arm_req = 1'b1;
      @(negedge clk);
      arm_req = 1'b0;
      for (int i = 1; i <= 20; i++) tick(pk(1000, 1000, 1000, 1000), 2'd1);
    end
    @(negedge clk);
    frame_tick = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_state", 64'(state), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_motor_sequencer.md
Name: pwm_motor_sequencer

Overview:
- Sequences the four motor channels of the PWM peripheral: ESC arming, per-frame slew-limited duty updates, command watchdog, failsafe.
- Sits between the flight-control command source and the PWM compare registers.
- Presents duty values plus a one-cycle load strobe aligned to the PWM frame boundary, so all four motors update together.

Parameters:
- DUTY_WIDTH, 16, width of one channel duty value.
- DUTY_MIN, 1000, idle/disarmed duty (ESC minimum throttle).
- DUTY_MAX, 2000, maximum permitted duty.
- ARM_FRAMES, 50, frames DUTY_MIN is held before ARMED.
- SLEW_STEP, 20, maximum per-frame duty change per channel.
- WDOG_FRAMES, 25, frames without an accepted command before FAILSAFE.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse at each PWM period boundary.
- arm_req  in  1  level or pulse; request arming.
- disarm_req  in  1  level or pulse; request disarm.
- cmd_valid  in  1  command handshake valid.
- cmd_ready  out  1  command handshake ready.
- cmd_duty  in  4*DUTY_WIDTH  target duties; channel i at [i*DUTY_WIDTH +: DUTY_WIDTH].
- duty_out  out  4*DUTY_WIDTH  registered duties to the PWM compare registers, same packing.
- duty_load  out  1  one-cycle strobe; the PWM latches duty_out.
- armed  out  1  high in ARMED.
- failsafe  out  1  high in FAILSAFE.
- state  out  2  0 DISARMED, 1 ARM_HOLD, 2 ARMED, 3 FAILSAFE.

Behaviour:
- **Clock and reset:** one clock, s00_axi_aclk. Reset s00_axi_areset is synchronous and active-high.
- **Reset values:** state=DISARMED; duty_out all DUTY_MIN; target registers all DUTY_MIN; duty_load=0; armed=0; failsafe=0; cmd_ready=0; frame and watchdog counters 0.
- **cmd_ready:** 1 every cycle after reset deasserts.
- **Command acceptance:** a command is accepted when cmd_valid&cmd_ready.
  - Each channel is clamped to [DUTY_MIN, DUTY_MAX], unsigned, then stored in the target registers.
  - Accepted outside ARMED: discarded. Targets are not updated and there is no stall.
- **DISARMED:**
  - duty_out held at DUTY_MIN.
  - arm_req (without disarm_req) → ARM_HOLD. Frame counter cleared; targets set to DUTY_MIN.
- **ARM_HOLD:**
  - duty_out held at DUTY_MIN. Counts frame_ticks.
  - On the ARM_FRAMES-th tick → ARMED, with the watchdog cleared.
  - arm_req is ignored.
- **ARMED, on each frame_tick:**
  - Per channel: d = target − duty_out (signed, DUTY_WIDTH+1 bits).
  - duty_out += d if |d| ≤ SLEW_STEP; otherwise ±SLEW_STEP.
  - Result never leaves [DUTY_MIN, DUTY_MAX].
- **Watchdog (ARMED only):**
  - Increments on each frame_tick; cleared on each accepted command.
  - Accept and tick in the same cycle: clear wins.
  - Reaching WDOG_FRAMES → FAILSAFE.
- **FAILSAFE:**
  - On the next frame_tick, duty_out is forced directly to DUTY_MIN (no slew). Held there afterwards.
  - Sticky: exit only via disarm_req or reset.
- **disarm_req:** from any state → DISARMED in the next cycle.
  - duty_out forced to DUTY_MIN immediately (no slew); targets reset to DUTY_MIN.
  - duty_load pulses in the same cycle duty_out changes.
  - disarm_req has priority over arm_req, frame_tick and commands.
- **Update latency:** frame_tick at cycle N → updated duty_out and duty_load=1 at N+1.
  - duty_load pulses on every frame_tick in all states, so the PWM is refreshed each frame even if unchanged.
- **Command vs tick in the same cycle:** the slew uses the old target; the new target applies from the next tick.
- **Reset mid-operation:** immediate return to reset values at the next clock edge, regardless of state or pending tick.
- **Handshake ordering:** accept-then-tick ordering holds across back-to-back commands. Only the last accepted command before a tick is used.

Test Plan:
1. **Reset and arming.** Reset 3 cycles; arm_req pulse; 50 frame_ticks.
   - During hold: state=1, duty_out=1000×4, one duty_load per tick.
   - After tick 50: state=2, armed=1.
2. **Slew limiting.** In ARMED, cmd_duty={1500,1010,1000,2500}; 3 ticks.
   - After tick 1: {1020,1010,1000,1020}. After tick 3: {1060,1010,1000,1060}.
   - Channel 3 target clamped to 2000. Ramp down from 1060 to target 1000 takes 3 ticks.
3. **Watchdog.** Armed, one command, then 25 ticks with no command.
   - failsafe=1, state=3. Next tick: duty_out=1000×4 in one step.
   - Further commands are ignored until disarm_req → state=0.
4. **Watchdog clear wins.** Command accepted in the same cycle as tick 25.
   - Remains ARMED; watchdog restarts from 0.
5. **Disarm priority.** arm_req and disarm_req together while ARMED at duty 1400.
   - Next cycle: state=0, duty_out=1000×4, duty_load=1, armed=0.
6. **Reset mid-operation.** Reset asserted in ARM_HOLD at frame 20 with a simultaneous frame_tick.
   - Next cycle: all outputs at reset values; no duty_load.
